// File: rtl/spi_master_tx_multi_cs.sv
// Transmit-only SPI master: one word per handshake, MSB first, routed to one of
// NUM_CS active-low chip selects with programmable CS setup and inactive times.
module spi_master_tx_multi_cs #(
  parameter int SPI_MODE          = 0,
  parameter int CLKS_PER_HALF_BIT = 2,
  parameter int DATA_WIDTH        = 8,
  parameter int NUM_CS            = 2,
  parameter int CS_SETUP_CLKS     = 1,
  parameter int CS_INACTIVE_CLKS  = 1,
  localparam int CS_SEL_W         = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [CS_SEL_W-1:0]   cs_sel_i,
  input  logic                  data_valid_i,
  output logic                  data_ready_o,
  output logic                  busy_o,
  output logic                  spi_clk_o,
  output logic                  spi_mosi_o,
  output logic [NUM_CS-1:0]     spi_cs_o,
  output logic [1:0]            fsm_state_o
);

  localparam logic CPOL   = 1'((SPI_MODE >> 1) & 1);
  localparam logic CPHA   = 1'(SPI_MODE & 1);
  localparam int   HALF_W = $clog2(CLKS_PER_HALF_BIT) + 1;
  localparam int   EDGE_W = $clog2(2 * DATA_WIDTH) + 1;
  localparam int   CS_MAX = (CS_SETUP_CLKS > CS_INACTIVE_CLKS) ? CS_SETUP_CLKS : CS_INACTIVE_CLKS;
  localparam int   CSC_W  = $clog2(CS_MAX + 1) + 1;

  localparam logic [HALF_W-1:0] HALF_LAST  = HALF_W'(CLKS_PER_HALF_BIT - 1);
  localparam logic [EDGE_W-1:0] EDGE_TOTAL = EDGE_W'(2 * DATA_WIDTH);
  localparam logic [EDGE_W-1:0] EDGE_LAST  = EDGE_W'(2 * DATA_WIDTH - 1);
  localparam logic [CSC_W-1:0]  SETUP_LAST = CSC_W'(CS_SETUP_CLKS - 1);
  localparam logic [CSC_W-1:0]  INACT_LAST = CSC_W'(CS_INACTIVE_CLKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETUP    = 2'd1,
    ST_TRANSFER = 2'd2,
    ST_INACTIVE = 2'd3
  } state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
  logic [HALF_W-1:0]     half_cnt, half_cnt_nxt;
  logic [EDGE_W-1:0]     edge_cnt, edge_cnt_nxt;
  logic [CSC_W-1:0]      cs_cnt, cs_cnt_nxt;
  logic [NUM_CS-1:0]     cs_nxt;
  logic                  sclk_nxt, mosi_nxt, ready_nxt, busy_nxt;
  logic                  sel_ok, shift_now;

  // Handshake: a word transfers on any posedge where data_valid_i and
  // data_ready_o are both high; ready is only high in IDLE, so valid asserted
  // while busy is simply left pending until the block returns to IDLE.
  assign sel_ok      = (32'(cs_sel_i) < NUM_CS);
  assign fsm_state_o = state;

  // Next bit goes out on trailing edges for CPHA=0 (except the final one) and on
  // leading edges after the first for CPHA=1; edge_cnt is even on leading edges.
  assign shift_now = (CPHA == 1'b0) ? (edge_cnt[0] && (edge_cnt != EDGE_LAST))
                                    : (!edge_cnt[0] && (edge_cnt != '0));

  always_comb begin
    state_nxt    = state;
    shreg_nxt    = shreg;
    half_cnt_nxt = half_cnt;
    edge_cnt_nxt = edge_cnt;
    cs_cnt_nxt   = cs_cnt;
    cs_nxt       = spi_cs_o;
    sclk_nxt     = spi_clk_o;
    mosi_nxt     = spi_mosi_o;
    ready_nxt    = data_ready_o;
    busy_nxt     = busy_o;
    case (state)
      ST_IDLE: begin
        ready_nxt = 1'b1;
        busy_nxt  = 1'b0;
        if (data_valid_i && sel_ok) begin
          shreg_nxt    = data_i;
          cs_nxt       = ~(NUM_CS'(1) << cs_sel_i);
          mosi_nxt     = data_i[DATA_WIDTH-1];
          ready_nxt    = 1'b0;
          busy_nxt     = 1'b1;
          cs_cnt_nxt   = '0;
          half_cnt_nxt = '0;
          edge_cnt_nxt = '0;
          state_nxt    = (CS_SETUP_CLKS == 0) ? ST_TRANSFER : ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cs_cnt == SETUP_LAST) state_nxt = ST_TRANSFER;
        else                      cs_cnt_nxt = cs_cnt + CSC_W'(1);
      end
      ST_TRANSFER: begin
        if (half_cnt != '0) begin
          half_cnt_nxt = half_cnt - HALF_W'(1);
        end else if (edge_cnt == EDGE_TOTAL) begin
          cs_nxt     = '1;
          mosi_nxt   = 1'b0;
          cs_cnt_nxt = '0;
          if (CS_INACTIVE_CLKS == 0) begin
            state_nxt = ST_IDLE;
            ready_nxt = 1'b1;
            busy_nxt  = 1'b0;
          end else begin
            state_nxt = ST_INACTIVE;
          end
        end else begin
          sclk_nxt     = ~spi_clk_o;
          half_cnt_nxt = HALF_LAST;
          edge_cnt_nxt = edge_cnt + EDGE_W'(1);
          if (shift_now) begin
            mosi_nxt  = shreg[DATA_WIDTH-2];
            shreg_nxt = {shreg[DATA_WIDTH-2:0], 1'b0};
          end
        end
      end
      ST_INACTIVE: begin
        if (cs_cnt == INACT_LAST) begin
          state_nxt = ST_IDLE;
          ready_nxt = 1'b1;
          busy_nxt  = 1'b0;
        end else begin
          cs_cnt_nxt = cs_cnt + CSC_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cs_nxt    = '1;
        sclk_nxt  = CPOL;
        mosi_nxt  = 1'b0;
        ready_nxt = 1'b1;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= ST_IDLE;
      shreg        <= '0;
      half_cnt     <= '0;
      edge_cnt     <= '0;
      cs_cnt       <= '0;
      spi_cs_o     <= '1;
      spi_clk_o    <= CPOL;
      spi_mosi_o   <= 1'b0;
      data_ready_o <= 1'b1;
      busy_o       <= 1'b0;
    end else begin
      state        <= state_nxt;
      shreg        <= shreg_nxt;
      half_cnt     <= half_cnt_nxt;
      edge_cnt     <= edge_cnt_nxt;
      cs_cnt       <= cs_cnt_nxt;
      spi_cs_o     <= cs_nxt;
      spi_clk_o    <= sclk_nxt;
      spi_mosi_o   <= mosi_nxt;
      data_ready_o <= ready_nxt;
      busy_o       <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_spi_master_tx_multi_cs.sv
// Bench for spi_master_tx_multi_cs: several parameter sets, each with a table of
// directed words, a mid-word reset, and random words against a serial-bus model.
module tb_spi_master_tx_multi_cs;

  localparam int NB = 5;
  localparam int C_MODE [NB] = '{0, 3, 1, 2, 0};
  localparam int C_W    [NB] = '{8, 16, 8, 8, 5};
  localparam int C_H    [NB] = '{2, 2, 2, 2, 3};
  localparam int C_NCS  [NB] = '{3, 2, 2, 2, 1};
  localparam int C_S    [NB] = '{1, 1, 3, 3, 0};
  localparam int C_I    [NB] = '{1, 4, 1, 1, 0};

  typedef struct {
    logic [31:0] data;
    int          sel;
    bit          hold;
    bit          exp_tx;
  } vec_t;

  // clock/reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  bit done [NB];

  task automatic chk(input string name, input int blk, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL b%0d %s: got %0h expected %0h (t=%0t)", blk, name, act, exp, $time);
    end
  endtask

  for (genvar b = 0; b < NB; b++) begin : g
    localparam int  W     = C_W[b];
    localparam int  H     = C_H[b];
    localparam int  NCS   = C_NCS[b];
    localparam int  S     = C_S[b];
    localparam int  I     = C_I[b];
    localparam logic CPOL = 1'(C_MODE[b] / 2);
    localparam logic CPHA = 1'(C_MODE[b] % 2);
    localparam int  SELW  = (NCS > 1) ? $clog2(NCS) : 1;
    localparam int  TOTAL = S + 2 * W * H + I + 1;
    localparam logic [NCS-1:0] ALL1 = '1;
    localparam logic [31:0] MASK = (32'd1 << W) - 32'd1;

    logic            rst, valid, ready, busy, sclk, mosi;
    logic [W-1:0]    data;
    logic [SELW-1:0] sel;
    logic [NCS-1:0]  cs;
    logic [1:0]      st;

    spi_master_tx_multi_cs #(
      .SPI_MODE(C_MODE[b]), .CLKS_PER_HALF_BIT(H), .DATA_WIDTH(W),
      .NUM_CS(NCS), .CS_SETUP_CLKS(S), .CS_INACTIVE_CLKS(I)
    ) dut (
      .clk_i(clk), .rst_i(rst), .data_i(data), .cs_sel_i(sel),
      .data_valid_i(valid), .data_ready_o(ready), .busy_o(busy),
      .spi_clk_o(sclk), .spi_mosi_o(mosi), .spi_cs_o(cs), .fsm_state_o(st)
    );

    // scoreboard: words expected on the bus, in order, with their CS line
    logic [31:0] exp_q [$];
    int          exp_sel_q [$];

    // bus monitor: rebuilds each word from SCLK/MOSI as a slave would see it
    initial begin
      bit          active = 0;
      int          start_cyc = 0, first_edge = -1, nedges = 0, bad = 0, cs_idx = -1;
      int          last_rise = -1;
      logic [31:0] bits = '0;
      logic        sclk_p = CPOL, mosi_p = 1'b0, lead = 1'b0;
      logic [NCS-1:0] cs_p = '1;
      forever begin
        @(negedge clk);
        if (rst !== 1'b1) begin
          active = 0;
          last_rise = -1;
        end else if (!active && cs !== ALL1) begin
          active = 1; start_cyc = cyc; first_edge = -1; nedges = 0; bad = 0; bits = '0;
          cs_idx = -1;
          for (int i = 0; i < NCS; i++) if (!cs[i]) cs_idx = i;
          chk("cs_onehot", b, $countones(~cs), 1);
          chk("sclk_idle_at_cs", b, sclk, CPOL);
          if (last_rise >= 0) chk("cs_high_gap_ge_inactive", b, 32'(start_cyc - last_rise >= I), 1);
        end else if (active && cs === ALL1) begin
          active = 0;
          last_rise = cyc;
          chk("edge_count", b, nedges, 2 * W);
          chk("sclk_end_cpol", b, sclk, CPOL);
          chk("setup_gap", b, first_edge - start_cyc, S + 1);
          chk("cs_low_len", b, cyc - start_cyc, S + 2 * W * H + 1);
          chk("mosi_line_stable", b, bad, 0);
          chk("mosi_idle", b, mosi, 1'b0);
          if (exp_q.size() == 0) begin
            chk("unexpected_word", b, bits, 32'hFFFF_FFFF);
          end else begin
            chk("word", b, bits, exp_q.pop_front());
            chk("cs_line", b, cs_idx, exp_sel_q.pop_front());
          end
        end else if (active) begin
          if (cs !== cs_p) bad++;
          lead = (sclk != CPOL);
          if (sclk !== sclk_p) begin
            if (first_edge < 0) first_edge = cyc;
            nedges++;
            if (lead == (CPHA == 1'b0)) bits = {bits[30:0], mosi};
          end
          if (mosi !== mosi_p && !(sclk !== sclk_p && lead != (CPHA == 1'b0))) bad++;
        end
        sclk_p = sclk;
        mosi_p = mosi;
        cs_p   = cs;
      end
    end

    // driver: present one word, observe the handshake and the return of ready
    task automatic send(input logic [31:0] d, input int s, input bit hold, input bit exp_tx);
      int k;
      int t = 0;
      while (ready !== 1'b1 && t < 2 * TOTAL) begin @(negedge clk); t++; end
      chk("ready_before_send", b, ready, 1'b1);
      data  = W'(d);
      sel   = SELW'(s);
      valid = 1'b1;
      @(negedge clk);
      k = cyc;
      if (exp_tx) begin
        exp_q.push_back(d & MASK);
        exp_sel_q.push_back(s);
      end
      if (!hold) valid = 1'b0;
      data = W'($urandom);
      if (!hold) sel = SELW'($urandom);
      if (exp_tx) begin
        chk("ready_low_after_accept", b, ready, 1'b0);
        chk("busy_high_after_accept", b, busy, 1'b1);
        t = 0;
        while (ready !== 1'b1 && t < 2 * TOTAL) begin @(negedge clk); t++; end
        chk("ready_latency", b, cyc - k, TOTAL);
        chk("busy_low_at_ready", b, busy, 1'b0);
      end else begin
        for (int j = 0; j < 3; j++) begin
          chk("drop_ready_stays", b, ready, 1'b1);
          chk("drop_busy_stays", b, busy, 1'b0);
          chk("drop_no_cs", b, 32'(cs), 32'(ALL1));
          chk("drop_sclk_idle", b, sclk, CPOL);
          @(negedge clk);
        end
      end
    endtask

    // reset asserted partway through an all-ones word
    task automatic reset_mid();
      data  = W'(32'hFFFF_FFFF);
      sel   = '0;
      valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      repeat (S + 2 * H * 3 + 2) @(negedge clk);
      chk("busy_before_rst", b, busy, 1'b1);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("rst_cs_high", b, 32'(cs), 32'(ALL1));
      chk("rst_sclk_cpol", b, sclk, CPOL);
      chk("rst_mosi_low", b, mosi, 1'b0);
      chk("rst_ready", b, ready, 1'b1);
      chk("rst_busy", b, busy, 1'b0);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", b, ready, 1'b1);
      chk("cs_after_rst", b, 32'(cs), 32'(ALL1));
    endtask

    initial begin
      vec_t tbl [$];
      vec_t v;
      rst = 1'b0; valid = 1'b0; data = '0; sel = '0;
      repeat (3) @(negedge clk);
      chk("reset_cs", b, 32'(cs), 32'(ALL1));
      chk("reset_sclk", b, sclk, CPOL);
      chk("reset_mosi", b, mosi, 1'b0);
      chk("reset_ready", b, ready, 1'b1);
      chk("reset_busy", b, busy, 1'b0);
      @(posedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", b, ready, 1'b1);

      case (b)
        0: tbl = '{'{32'hA5, 1, 1'b0, 1'b1}, '{32'h3C, 0, 1'b0, 1'b1}, '{32'h55, 3, 1'b0, 1'b0},
                   '{32'hFF, 2, 1'b0, 1'b1}, '{32'h00, 2, 1'b0, 1'b1}};
        1: tbl = '{'{32'h8001, 0, 1'b0, 1'b1}, '{32'h12, 0, 1'b1, 1'b1}, '{32'h34, 1, 1'b0, 1'b1},
                   '{32'hFFFF, 1, 1'b0, 1'b1}};
        2: tbl = '{'{32'h3C, 0, 1'b0, 1'b1}, '{32'hC3, 1, 1'b1, 1'b1}, '{32'h81, 0, 1'b0, 1'b1}};
        3: tbl = '{'{32'h3C, 1, 1'b0, 1'b1}, '{32'h7E, 0, 1'b0, 1'b1}};
        default: tbl = '{'{32'h1F, 0, 1'b0, 1'b1}, '{32'h10, 0, 1'b1, 1'b1},
                         '{32'h01, 0, 1'b0, 1'b1}, '{32'h0A, 1, 1'b0, 1'b0}};
      endcase
      for (int n = 0; n < tbl.size(); n++) begin
        v = tbl[n];
        send(v.data, v.sel, v.hold, v.exp_tx);
      end

      reset_mid();
      send(32'hC5A3, 0, 1'b0, 1'b1);

      for (int r = 0; r < 8; r++) begin
        logic [31:0] d;
        int s;
        bit h;
        d = $urandom;
        s = $urandom_range(0, (1 << SELW) - 1);
        h = (r < 7) && (s < NCS) && ($urandom_range(0, 1) == 1);
        send(d, s, h, s < NCS);
      end

      repeat (TOTAL) @(negedge clk);
      chk("scoreboard_drained", b, exp_q.size(), 0);
      done[b] = 1'b1;
    end
  end

  initial begin
    int t = 0;
    bit all_done = 0;
    while (!all_done && t < 60000) begin
      @(negedge clk);
      t++;
      all_done = 1;
      for (int i = 0; i < NB; i++) if (!done[i]) all_done = 0;
    end
    if (!all_done) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: blocks not finished after %0d cycles", t);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
